fetch_queue: RTL
================

# fetch_queue

Parametrised instruction fetch unit with a decoupling queue, replacing the single-entry PC, stall mux and invalid-bit chain in the fetch phase. It owns the fetch PC, issues sequential reads to the 1-cycle synchronous instruction RAM, buffers returned instructions with their addresses, and hands them to decode over a valid/ready handshake. A redirect from EX (branch or PC write) flushes all wrong-path state in one cycle.

## Interface
- ADDR_W, 32, fetch address width (byte address)
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 0, fetch PC after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- redirect_en  in  1  pulse from EX: branch taken or PC written
- redirect_pc  in  ADDR_W  new fetch PC, word aligned
- imem_req  out  1  read strobe to instruction RAM
- imem_addr  out  ADDR_W  read address
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_req
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_addr  out  ADDR_W  head instruction address
- perf_flush_cnt  out  32  redirects seen (FETCHQ_PERF_EN)
- perf_empty_cnt  out  32  cycles with out_valid low and out_ready high (FETCHQ_PERF_EN)

## Operation
- Fetch PC register fpc; imem_addr = fpc; fpc += 4 on each issued request.
- inflight flag: 1 when a request was issued last cycle and not squashed.
- Issue rule: imem_req = ~reset & ~redirect_en & (count + inflight - pop < DEPTH), pop = out_valid & out_ready. Queue never overflows.
- Response: when inflight, imem_rdata and its address (stored with the request) written at tail.
- Pop: head advances when out_valid & out_ready.
- Simultaneous write and pop: both happen; count unchanged.
- Redirect (cycle t): count := 0, head/tail := 0, inflight := 0 (response arriving at t+1 discarded), fpc := redirect_pc; no request issued at t. Pop at t is ignored by the queue; decode treats it as wrong-path.
- Redirect while queue empty or full: same behaviour.
- Reset: fpc = RESET_PC, count = 0, inflight = 0; reset wins over redirect.
- count width $clog2(DEPTH+1); head/tail pointers $clog2(DEPTH), natural wrap.
- Misaligned redirect_pc: low two bits forced to 0.

## Timing
- Reset values: out_valid 0, imem_req 0, imem_addr RESET_PC, out_instr 0, out_addr 0, perf counters 0.
- Request at cycle c -> entry visible (out_valid) at c+2.
- First fetch: request in first cycle with reset low (cycle 0); out_valid at cycle 2 with out_addr = RESET_PC.
- Redirect at t: out_valid low at t+1, t+2; request for redirect_pc at t+1; out_valid with out_addr = redirect_pc at t+3.
- Steady state with out_ready held high: one instruction per cycle, consecutive addresses.
- out_ready low for k cycles: queue fills to DEPTH, then imem_req low; resumes the cycle a pop occurs, no bubble beyond the latency.
- out_valid, out_instr, out_addr driven from registers only; no combinational path from out_ready or redirect_en to outputs other than imem_req.

## Configuration
- FETCHQ_PERF_EN defined: perf_flush_cnt increments on each redirect_en cycle, perf_empty_cnt on each cycle with ~out_valid & out_ready; both wrap at 2^32, clear on reset.
- Undefined: counters not built, both ports tied to 0; fetch behaviour identical.

## Structure
- Shared defines header: FETCHQ_DEPTH_DEFAULT, FETCHQ_PERF_W (32), instruction size constant (4).
- Sub-module fetchq_fifo: circular buffer of {addr, instr} with push, pop, flush, count, full/empty; fetch_queue holds fpc, inflight, issue logic and counters.

## Test plan
- Reset release, out_ready=1, RAM word n = n: out_valid at cycle 2, out_addr 0,4,8,... one per cycle, out_instr 0,1,2,...
- out_ready=0 for 10 cycles from cycle 2: count reaches 4, imem_req low after fills; release -> addresses 0..36 delivered in order, none lost or repeated.
- redirect_en at t with redirect_pc=0x100 while queue holds 3 entries: out_valid low at t+1,t+2, out_addr=0x100 at t+3, then 0x104; response in flight at t never appears.
- Back-to-back redirects at t (0x100) and t+1 (0x200): first out_addr is 0x200 at t+4; 0x100 never delivered.
- reset asserted mid-stream with queue full and redirect_en high: next cycle out_valid 0, imem_addr RESET_PC; restart as in first scenario.
- FETCHQ_PERF_EN: 3 redirects and 5 stall-free empty cycles -> perf_flush_cnt=3, perf_empty_cnt=5; undefined -> both read 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch unit and its decoupling queue.
package fetch_queue_pkg;

    localparam int FETCHQ_DEPTH_DEFAULT = 4;   // queue entries when not overridden
    localparam int FETCHQ_PERF_W        = 32;  // performance counter width
    localparam int FETCHQ_INSTR_BYTES   = 4;   // fetch PC step per instruction

endpackage

// File: rtl/fetchq_fifo.sv
// Circular buffer of {addr, instr} pairs between the instruction RAM and decode.
// A flush discards every entry in one cycle; push/pop in the same cycle as a
// flush are dropped. Storage clears on reset so the head reads 0 out of reset.
module fetchq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = FETCHQ_DEPTH_DEFAULT,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [ADDR_W-1:0]  i_push_addr,
    input  logic [INSTR_W-1:0] i_push_instr,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [ADDR_W-1:0]  o_head_addr,
    output logic [INSTR_W-1:0] o_head_instr,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_empty
);

    logic [ADDR_W-1:0]  r_addr  [DEPTH];
    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

    assign o_count      = r_count;
    assign o_head_addr  = r_addr[r_head];
    assign o_head_instr = r_instr[r_head];

    // Pointer and occupancy update; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + PTR_W'(1);
            if (w_do_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; written at the tail on push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]  <= '0;
                r_instr[i] <= '0;
            end
        end else if (w_do_push) begin
            r_addr[r_tail]  <= i_push_addr;
            r_instr[r_tail] <= i_push_instr;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues sequential reads to a
// 1-cycle synchronous instruction RAM and buffers the returned words in
// fetchq_fifo for decode. A redirect squashes the queue and any read in flight.
// Optional feature macro: FETCHQ_PERF_EN builds the redirect and empty-cycle
// performance counters; without it both counter ports read 0.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = FETCHQ_DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_en,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [FETCHQ_PERF_W-1:0] perf_flush_cnt,
    output logic [FETCHQ_PERF_W-1:0] perf_empty_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_inflight;

    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_pop;
    logic [OCC_W-1:0]  w_occ;
    logic              w_issue;
    logic [ADDR_W-1:0] w_redirect_aligned;

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;

    // Slots already committed (stored + in flight) after this cycle's pop;
    // a read is only issued when its response is guaranteed a slot.
    assign w_occ   = {1'b0, w_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_issue = ~reset & ~redirect_en & (w_occ < OCC_W'(DEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = r_fpc;

    assign w_redirect_aligned = redirect_pc & ~ADDR_W'(3);

    // Fetch PC, in-flight tracking and the address of the outstanding read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc      <= RESET_PC;
            r_req_addr <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_en) begin
                r_fpc <= w_redirect_aligned;
            end else if (w_issue) begin
                r_fpc      <= r_fpc + ADDR_W'(FETCHQ_INSTR_BYTES);
                r_req_addr <= r_fpc;
            end
        end
    end

    fetchq_fifo #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (r_inflight),
        .i_push_addr  (r_req_addr),
        .i_push_instr (imem_rdata),
        .i_pop        (w_pop),
        .i_flush      (redirect_en),
        .o_head_addr  (out_addr),
        .o_head_instr (out_instr),
        .o_count      (w_count),
        .o_empty      (w_empty)
    );

`ifdef FETCHQ_PERF_EN
    logic [FETCHQ_PERF_W-1:0] r_perf_flush;
    logic [FETCHQ_PERF_W-1:0] r_perf_empty;

    // Redirect count and decode-starved cycles; both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_flush <= '0;
            r_perf_empty <= '0;
        end else begin
            if (redirect_en)             r_perf_flush <= r_perf_flush + FETCHQ_PERF_W'(1);
            if (~out_valid & out_ready)  r_perf_empty <= r_perf_empty + FETCHQ_PERF_W'(1);
        end
    end

    assign perf_flush_cnt = r_perf_flush;
    assign perf_empty_cnt = r_perf_empty;
`else
    assign perf_flush_cnt = '0;
    assign perf_empty_cnt = '0;
`endif

endmodule
